// File: rtl/m_clk_div.sv
// -----------------------------------------------------------------------------
// m_clk_div
// Programmable integer clock divider built from registered logic only. It
// drives the clock-path XNOR polarity stage, so every output, clk_out included,
// comes straight from a flop. A ratio change is held back until the current
// output period ends. The downstream cell therefore never sees a runt pulse.
//
// Parameters
//   CNT_W      width of the ratio and the period counter
//   DEF_RATIO  ratio loaded at reset, 2 .. 2**CNT_W-1
//
// Ports
//   clk        block clock
//   rst        synchronous, active-high reset
//   en         run request, level-sensitive, acted on at period boundaries
//   cfg_valid  new ratio offered
//   cfg_ratio  offered ratio N (0 and 1 are clamped to 2)
//   cfg_ready  a ratio can be accepted
//   clk_out    divided clock: high floor(N/2) cycles, then low ceil(N/2) cycles
//   tick       one-cycle pulse in the last cycle of each output period
//   busy       high while running
//
// FSM states
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | stopped; clk_out low, cnt held at 0, ratios written directly
//   RUN   | dividing; cnt walks 0..N_act-1, ratio changes wait for the wrap
// -----------------------------------------------------------------------------
module m_clk_div #(
    parameter int CNT_W     = 8,
    parameter int DEF_RATIO = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_ratio,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_N   = CNT_W'(DEF_RATIO);
    localparam logic [CNT_W-1:0] CNT_ZRO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_act_q, n_act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;

    logic             xfer;
    logic             at_end;
    logic [CNT_W-1:0] ratio_clamped;

    // A ratio of 0 or 1 cannot be split into a high and a low phase.
    function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] r);
        return (r < MIN_N) ? MIN_N : r;
    endfunction

    assign xfer          = cfg_valid && cfg_ready_q;
    assign ratio_clamped = clamp_ratio(cfg_ratio);
    assign at_end        = (cnt_q == (n_act_q - ONE));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_act_d     = n_act_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        cfg_ready_d = cfg_ready_q;

        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZRO;
                // A ratio can be captured in the boundary cycle where RUN
                // stops. It is left pending and is applied here.
                if (pend_vld_q) begin
                    n_act_d     = pend_q;
                    pend_vld_d  = 1'b0;
                    cfg_ready_d = 1'b1;
                end else if (xfer) begin
                    n_act_d = ratio_clamped;
                end
                if (en) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // cfg_ready is high only when nothing is pending. A capture
                // therefore never overwrites an entry that is waiting.
                if (xfer) begin
                    pend_d      = ratio_clamped;
                    pend_vld_d  = 1'b1;
                    cfg_ready_d = 1'b0;
                end
                if (at_end) begin
                    cnt_d = CNT_ZRO;
                    if (pend_vld_q) begin
                        n_act_d     = pend_q;
                        pend_vld_d  = 1'b0;
                        cfg_ready_d = 1'b1;
                    end
                    if (!en) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZRO;
            end
        endcase

        // The outputs are computed from next state so that the registered
        // outputs line up with the registered cnt.
        busy_d    = (state_d == RUN);
        clk_out_d = (state_d == RUN) && (cnt_d < (n_act_d >> 1));
        tick_d    = (state_d == RUN) && (cnt_d == (n_act_d - ONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZRO;
            n_act_q     <= DEF_N;
            pend_q      <= CNT_ZRO;
            pend_vld_q  <= 1'b0;
            cfg_ready_q <= 1'b1;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_act_q     <= n_act_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            cfg_ready_q <= cfg_ready_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_m_clk_div.sv
// -----------------------------------------------------------------------------
// tb_m_clk_div
// Directed bench for m_clk_div. The driver applies one cycle of inputs at a
// time. It then queues the hand-computed outputs expected after that edge. A
// separate monitor pops one entry per cycle on the falling edge and compares
// it against {clk_out, tick, busy, cfg_ready}.
// -----------------------------------------------------------------------------
module tb_m_clk_div;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_ratio;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             busy;

    int n_tests;
    int n_fail;
    logic  [3:0] exp_q[$];
    string       nm_q[$];

    m_clk_div #(.CNT_W(CNT_W), .DEF_RATIO(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle, sampled away from the rising edge.
    always @(negedge clk) begin
        logic  [3:0] e;
        logic  [3:0] got;
        string       nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = nm_q.pop_front();
            got = {clk_out, tick, busy, cfg_ready};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: {clk_out,tick,busy,cfg_ready} got %b expected %b at %0t",
                         nm, got, e, $time);
            end
        end
    end

    // Drive one cycle of inputs. Queue the outputs expected after that edge.
    task automatic cyc(input logic r, input logic e, input logic v,
                       input logic [CNT_W-1:0] ratio, input logic [3:0] ex,
                       input string nm);
        rst       = r;
        en        = e;
        cfg_valid = v;
        cfg_ratio = ratio;
        @(posedge clk);
        #1;
        exp_q.push_back(ex);
        nm_q.push_back(nm);
    endtask

    task automatic run(input logic e, input logic [3:0] ex, input string nm);
        cyc(1'b0, e, 1'b0, 8'd0, ex, nm);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = '0;

        // Reset defaults, then run at DEF_RATIO=2.
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "reset_0");
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 4'b0001, "reset_1");
        run(1'b1, 4'b1011, "def_first_rise");
        run(1'b1, 4'b0111, "def_tick");
        run(1'b1, 4'b1011, "def_hi");
        run(1'b1, 4'b0111, "def_tick2");
        run(1'b0, 4'b0001, "def_stop");
        run(1'b0, 4'b0001, "def_idle");

        // Odd ratio 5 loaded in IDLE. en drops mid-period, which is ignored.
        cyc(1'b0, 1'b0, 1'b1, 8'd5, 4'b0001, "odd_load");
        run(1'b1, 4'b1011, "odd_c0");
        run(1'b1, 4'b1011, "odd_c1");
        run(1'b1, 4'b0011, "odd_c2");
        run(1'b1, 4'b0011, "odd_c3");
        run(1'b1, 4'b0111, "odd_c4");
        run(1'b1, 4'b1011, "odd_p2c0");
        run(1'b1, 4'b1011, "odd_p2c1");
        run(1'b1, 4'b0011, "odd_p2c2");
        run(1'b1, 4'b0011, "odd_p2c3");
        run(1'b0, 4'b0111, "odd_p2c4_endropped");
        run(1'b0, 4'b0001, "odd_stop");

        // Boundary switch from 4 to 6, then stop at cycle 1 of a 6-period.
        cyc(1'b0, 1'b0, 1'b1, 8'd4, 4'b0001, "sw_load4");
        run(1'b1, 4'b1011, "sw_n4c0");
        cyc(1'b0, 1'b1, 1'b1, 8'd6, 4'b1010, "sw_n4c1_pending");
        run(1'b1, 4'b0010, "sw_n4c2");
        run(1'b1, 4'b0110, "sw_n4c3");
        run(1'b1, 4'b1011, "sw_n6c0_ready");
        run(1'b1, 4'b1011, "sw_n6c1");
        run(1'b1, 4'b1011, "sw_n6c2");
        run(1'b1, 4'b0011, "sw_n6c3");
        run(1'b1, 4'b0011, "sw_n6c4");
        run(1'b1, 4'b0111, "sw_n6c5");
        run(1'b1, 4'b1011, "stop_c0");
        run(1'b1, 4'b1011, "stop_c1");
        run(1'b0, 4'b1011, "stop_c2");
        run(1'b0, 4'b0011, "stop_c3");
        run(1'b0, 4'b0011, "stop_c4");
        run(1'b0, 4'b0111, "stop_c5");
        run(1'b0, 4'b0001, "stop_idle");
        run(1'b0, 4'b0001, "stop_idle2");

        // Clamp 1 to 2, then back-pressure: 9 is held while 3 is pending.
        cyc(1'b0, 1'b0, 1'b1, 8'd1, 4'b0001, "clamp_load");
        run(1'b1, 4'b1011, "clamp_c0");
        cyc(1'b0, 1'b1, 1'b1, 8'd3, 4'b0110, "bp_pend3");
        cyc(1'b0, 1'b1, 1'b1, 8'd9, 4'b1011, "bp_n3c0_held");
        cyc(1'b0, 1'b1, 1'b1, 8'd9, 4'b0010, "bp_n3c1_acc9");
        run(1'b1, 4'b0110, "bp_n3c2");
        run(1'b1, 4'b1011, "bp_n9c0");
        for (int k = 1; k < 9; k++) begin
            run((k < 8), {(k < 4), (k == 8), 1'b1, 1'b1}, $sformatf("bp_n9c%0d", k));
        end
        run(1'b0, 4'b0001, "bp_stop");

        // Transfer together with en, then a mid-run reset with a ratio pending.
        cyc(1'b0, 1'b1, 1'b1, 8'd8, 4'b1011, "rst_n8c0");
        cyc(1'b0, 1'b1, 1'b1, 8'd5, 4'b1010, "rst_n8c1_pend5");
        run(1'b1, 4'b1010, "rst_n8c2");
        run(1'b1, 4'b1010, "rst_n8c3");
        cyc(1'b1, 1'b1, 1'b0, 8'd0, 4'b0001, "rst_mid");
        for (int k = 0; k < 6; k++) begin
            run(1'b1, (k % 2 == 0) ? 4'b1011 : 4'b0111, $sformatf("rst_def_%0d", k));
        end
        run(1'b0, 4'b0001, "rst_def_stop");

        // Maximum ratio 255: 127 high, 128 low, one tick at the very end.
        cyc(1'b0, 1'b0, 1'b1, 8'd255, 4'b0001, "max_load");
        run(1'b1, 4'b1011, "max_c0");
        for (int k = 1; k < 255; k++) begin
            run(1'b0, {(k < 127), (k == 254), 1'b1, 1'b1}, $sformatf("max_c%0d", k));
        end
        run(1'b0, 4'b0001, "max_stop");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m_clk_div.md
Name: m_clk_div

Overview:
- Programmable integer clock divider built from registered logic only; produces a glitch-free divided clock.
- Its clk_out feeds the clock-path XNOR cell stage directly downstream. That stage applies polarity selection (XNOR with a polarity bit) before the clock tree.
- Ratio changes are accepted through a valid/ready handshake and take effect only on a period boundary, so the downstream cell never sees a runt pulse.

Parameters:
- CNT_W, 8, width of the division ratio and the period counter.
- DEF_RATIO, 2, ratio loaded at reset; must be in the range 2..2^CNT_W-1.

Ports:
- clk  input  1  block clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run request; level-sensitive.
- cfg_valid  input  1  new ratio offered.
- cfg_ratio  input  CNT_W  offered ratio N.
- cfg_ready  output  1  block can accept a ratio.
- clk_out  output  1  divided clock, registered; goes to the downstream XNOR stage.
- tick  output  1  one-cycle pulse in the last cycle of each output period.
- busy  output  1  high while in RUN.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All outputs are driven from flops.
- Reset values:
  - clk_out=0, tick=0, busy=0, cfg_ready=1.
  - cnt=0, state=IDLE.
  - active ratio N_act=DEF_RATIO; pending register empty.
- Phase split: for active ratio N, high phase length H=floor(N/2), low phase length L=N-H. Odd N therefore gives the longer low phase (N=5 → 2 high, 3 low).
- Clamping: a cfg_ratio of 0 or 1 is clamped to 2 when captured.
- State IDLE:
  - cnt=0, clk_out=0, busy=0.
  - If en=1 is sampled, the next cycle enters RUN with cnt=0, clk_out=1, busy=1. Latency from en to the first clk_out rise is 1 cycle.
- State RUN:
  - cnt increments each cycle, 0..N_act-1.
  - clk_out is registered as (cnt_next < H), so it is high for the first H cycles of each period.
  - tick=1 in the cycle where cnt==N_act-1.
- Period boundary (cnt==N_act-1):
  - cnt wraps to 0.
  - If a pending ratio exists, it becomes N_act for the new period, the pending register clears, and cfg_ready rises on the next cycle.
  - If en=0 at the boundary, go to IDLE with clk_out=0. The current period always completes.
  - If en=0 and a pending ratio exist together, the pending ratio is still applied to N_act and the block stops.
- en deasserted mid-period: ignored until the boundary. No truncated pulse.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready. cfg_ratio is captured into pending and cfg_ready drops on the next cycle.
  - Only one pending entry exists; cfg_ready stays 0 until that entry is applied.
  - In IDLE, a transfer writes N_act directly on the next cycle and cfg_ready stays 1.
  - Transfer and en rising in the same IDLE cycle: the first RUN period uses the new ratio.
- cfg_valid while cfg_ready=0: the request is held off and no capture occurs. The upstream side must hold cfg_valid and cfg_ratio stable until accepted.
- rst asserted mid-operation: all state returns to reset values on the next edge. clk_out goes low immediately on that edge and the pending ratio is discarded.
- Max ratio: N=2^CNT_W-1. cnt never exceeds N_act-1, and no wrap occurs beyond CNT_W bits.

Test Plan:
- Reset default: rst 2 cycles, en=1 with DEF_RATIO=2 → clk_out toggles every cycle starting 1 cycle after en, tick every 2nd cycle, busy=1.
- Odd ratio: in IDLE, cfg_ratio=5 handshake, then en=1 → clk_out pattern 1,1,0,0,0 repeating; tick on the 5th cycle of each period; cfg_ready stays 1.
- Boundary switch: running at N=4, offer N=6 mid-period → cfg_ready drops next cycle; the current 4-cycle period completes; the next period is 3 high, 3 low; cfg_ready returns to 1 after the switch; no high or low phase shorter than 2 cycles in between.
- Stop: N=6, drop en at cycle 1 of a period → 5 more cycles run; IDLE at the boundary with clk_out=0, busy=0; no partial pulse.
- Clamp and back-pressure: offer cfg_ratio=1 → N_act=2. While a ratio is pending, hold cfg_valid with ratio 9 → not accepted until cfg_ready=1, then accepted once.
- Mid-run reset: N=8 running, rst pulsed at cnt=3 → next cycle clk_out=0, busy=0, cfg_ready=1, N_act=DEF_RATIO, pending cleared.
